// File: rtl/tag_lookup_pkg.sv
// -----------------------------------------------------------------------------
// tag_lookup_pkg
// Shared constants and types for the cache tag-lookup controller.
//   - Address split: {tag[22:0], index[4:0], offset[3:0]} of a 32-bit address.
//   - state_t: controller FSM states.
//   - addr_fields_t: packed view of a request address.
// -----------------------------------------------------------------------------
package tag_lookup_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = 5;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS     = 1 << INDEX_W;
    localparam int SRAM_W   = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        MISS = 3'd2,
        FILL = 3'd3,
        RESP = 3'd4
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

endpackage

// File: rtl/tag_valid_bits.sv
// -----------------------------------------------------------------------------
// tag_valid_bits
// One valid flop per set. The tag SRAM has no reset, so these flops are the
// only thing that says whether a stored tag means anything.
// Ports:
//   CLK, RSTn          clock, synchronous active-low reset (clears all bits)
//   set_en, set_idx    mark a set valid (refill complete)
//   clr_en, clr_idx    mark a set invalid (invalidate request)
//   rd_idx, rd_valid   combinational read of one bit
// -----------------------------------------------------------------------------
module tag_valid_bits
    import tag_lookup_pkg::*;
(
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               set_en,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] clr_idx,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid
);

    logic [SETS-1:0] valid_q;

    // Set wins if both hit the same index; the controller never does both in
    // one cycle (clear only in IDLE, set only in FILL).
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            valid_q <= '0;
        end else begin
            if (clr_en) valid_q[clr_idx] <= 1'b0;
            if (set_en) valid_q[set_idx] <= 1'b1;
        end
    end

    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/tag_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tag_lookup_ctrl
// Tag-lookup controller in front of a 32x32 tag SRAM macro. Resolves each
// lookup to hit or miss; on a miss it requests a refill and then writes the
// new tag into the SRAM and marks the set valid.
//
// Ports:
//   CLK, RSTn                    clock, synchronous active-low reset
//   req_valid/req_ready/req_addr lookup request
//   resp_valid/resp_ready/resp_hit  lookup result
//   miss_valid/miss_addr         refill request (line aligned), miss_done pulse
//   inv_valid/inv_index          invalidate one set (accepted in IDLE only)
//   tag_CEB/WEB/A/D/BWEB, tag_Q  SRAM macro pins (Q valid one cycle after read)
//   hit_cnt/miss_cnt             lookup statistics
//   dbg_state                    current FSM state
//
// Build option: define TAG_STAT_EN to get the hit/miss counters; without it
// the counter outputs are tied to zero.
//
// Handshakes: a transfer happens on a CLK edge where valid and ready are both
// high. A producer holds valid and its payload unchanged until that edge;
// ready may depend on the state only (req_ready also drops while inv_valid is
// high, because an invalidate takes the IDLE cycle).
// -----------------------------------------------------------------------------
module tag_lookup_ctrl
    import tag_lookup_pkg::*;
(
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic                miss_valid,
    output logic [ADDR_W-1:0]   miss_addr,
    input  logic                miss_done,
    input  logic                inv_valid,
    input  logic [INDEX_W-1:0]  inv_index,
    output logic                tag_CEB,
    output logic                tag_WEB,
    output logic [INDEX_W-1:0]  tag_A,
    output logic [SRAM_W-1:0]   tag_D,
    output logic [SRAM_W-1:0]   tag_BWEB,
    input  logic [SRAM_W-1:0]   tag_Q,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
    output state_t              dbg_state
);

    state_t       state_q, state_d;
    addr_fields_t req_q;
    addr_fields_t req_in;
    logic         resp_hit_q;
    logic         accept;
    logic         hit;
    logic         set_valid;

    assign req_in    = split_addr(req_addr);
    assign req_ready = (state_q == IDLE) && !inv_valid;
    assign accept    = req_valid && req_ready;

    tag_valid_bits u_valid (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .set_en   (state_q == FILL),
        .set_idx  (req_q.index),
        .clr_en   ((state_q == IDLE) && inv_valid),
        .clr_idx  (inv_index),
        .rd_idx   (req_q.index),
        .rd_valid (set_valid)
    );

    // Only meaningful in CMP, where tag_Q holds the read issued in IDLE.
    assign hit = set_valid && (tag_Q[TAG_W-1:0] == req_q.tag);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            req_q      <= '0;
            resp_hit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept)            req_q      <= req_in;
            if (state_q == CMP)    resp_hit_q <= hit;
            if (state_q == FILL)   resp_hit_q <= 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        tag_CEB  = 1'b1;
        tag_WEB  = 1'b1;
        tag_A    = '0;
        tag_D    = '0;
        tag_BWEB = '1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_CEB = 1'b0;
                    tag_A   = req_in.index;
                    state_d = CMP;
                end
            end
            CMP:  state_d = hit ? RESP : MISS;
            MISS: if (miss_done) state_d = FILL;
            FILL: begin
                tag_CEB  = 1'b0;
                tag_WEB  = 1'b0;
                tag_A    = req_q.index;
                tag_D    = {{(SRAM_W-TAG_W){1'b0}}, req_q.tag};
                tag_BWEB = '0;
                state_d  = RESP;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid = (state_q == RESP);
    assign resp_hit   = resp_hit_q;
    assign miss_valid = (state_q == MISS);
    assign miss_addr  = {req_q.tag, req_q.index, {OFFSET_W{1'b0}}};
    assign dbg_state  = state_q;

`ifdef TAG_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == CMP) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

    // Upper SRAM bits are always written as zero and the line offset never
    // reaches the SRAM or the refill address.
    logic unused_bits;
    assign unused_bits = ^{tag_Q[SRAM_W-1:TAG_W], req_q.offset};

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
`timescale 1ns/1ps
module tb_tag_lookup_ctrl;
    import tag_lookup_pkg::*;

`ifdef TAG_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    always #5 CLK = ~CLK;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_hit;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_done = 1'b0;
    logic        inv_valid = 1'b0;
    logic [4:0]  inv_index = '0;
    logic        tag_CEB, tag_WEB;
    logic [4:0]  tag_A;
    logic [31:0] tag_D, tag_BWEB;
    logic [31:0] tag_Q;
    logic [31:0] hit_cnt, miss_cnt;
    state_t      dbg_state;

    tag_lookup_ctrl dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_done(miss_done),
        .inv_valid(inv_valid), .inv_index(inv_index),
        .tag_CEB(tag_CEB), .tag_WEB(tag_WEB), .tag_A(tag_A), .tag_D(tag_D),
        .tag_BWEB(tag_BWEB), .tag_Q(tag_Q),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
    );

    // ---------------- SRAM model (no reset, garbage contents) ----------------
    logic        preload = 1'b1;
    logic [31:0] mem [32];
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= $urandom;
            mem[3] <= 32'h0000_0009;   // matches tag of 0x1230: only valid bit can say miss
            mem[7] <= 32'h0000_002B;   // matches tag of 0x5670
        end else if (!tag_CEB) begin
            if (!tag_WEB) mem[tag_A] <= (mem[tag_A] & tag_BWEB) | (tag_D & ~tag_BWEB);
            else          tag_Q <= mem[tag_A];
        end
    end

    // ---------------- bus monitor ----------------
    int          wr_cnt = 0;
    int          miss_seen = 0;
    logic [4:0]  last_wr_a;
    logic [31:0] last_wr_d, last_wr_bweb;
    always @(negedge CLK) begin
        #2;
        if (!tag_CEB && !tag_WEB) begin
            wr_cnt++;
            last_wr_a    = tag_A;
            last_wr_d    = tag_D;
            last_wr_bweb = tag_BWEB;
        end
        if (miss_valid) miss_seen++;
    end

    // ---------------- reference model + scoreboard ----------------
    logic        mdl_valid [32];
    logic [22:0] mdl_tag [32];
    logic [0:0]  resp_exp_q[$];
    logic [31:0] miss_exp_q[$];
    int          exp_hits = 0, exp_misses = 0;
    int          n_checks = 0, n_errors = 0;

    task automatic predict(input logic [31:0] addr);
        logic [4:0]  idx;
        logic [22:0] tg;
        logic        h;
        idx = addr[8:4];
        tg  = addr[31:9];
        h   = mdl_valid[idx] && (mdl_tag[idx] == tg);
        resp_exp_q.push_back(h);
        if (h) exp_hits++;
        else begin
            exp_misses++;
            miss_exp_q.push_back({addr[31:4], 4'b0000});
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx]   = tg;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mdl_valid[i] = 1'b0;
            mdl_tag[i]   = '0;
        end
        resp_exp_q.delete();
        miss_exp_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge of the CMP cycle.
    task automatic send_req(input logic [31:0] addr, output logic ok,
                            output logic ceb, output logic [4:0] a);
        ok = 1'b0; ceb = 1'b1; a = '0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready) begin
                ok  = 1'b1;
                ceb = tag_CEB;
                a   = tag_A;
            end
            @(negedge CLK);
            if (ok) break;
        end
        req_valid = 1'b0;
        if (ok) predict(addr);
    endtask

    // Counts cycles (current cycle = 1) until resp_valid or miss_valid.
    task automatic wait_out(input bit want_miss, output int n, output logic ok);
        n = 1; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (want_miss ? miss_valid : resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic pulse_done();
        miss_done = 1'b1;
        @(negedge CLK);
        miss_done = 1'b0;
    endtask

    // ---------------- scenario tasks ----------------
    // Finishes a lookup accepted one cycle ago, following the scoreboard.
    task automatic complete_lookup();
        logic        exp_h, ok;
        logic [31:0] exp_ma;
        int          n, w0, m0;
        w0 = wr_cnt;
        m0 = miss_seen;
        n_checks++;
        if (resp_exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_empty: got no queued response, required one");
            return;
        end
        exp_h = resp_exp_q.pop_front();
        if (!exp_h) begin
            wait_out(1'b1, n, ok);
            n_checks++;
            if (!ok || n != 2) begin
                n_errors++;
                $display("FAIL miss_latency: got seen=%0b cycles=%0d, required 1/2", ok, n);
            end
            exp_ma = miss_exp_q.pop_front();
            n_checks++;
            if (miss_addr !== exp_ma) begin
                n_errors++;
                $display("FAIL miss_addr: got %h required %h", miss_addr, exp_ma);
            end
            @(negedge CLK); @(negedge CLK); #1;
            n_checks++;
            if (miss_valid !== 1'b1 || miss_addr !== exp_ma || wr_cnt != w0) begin
                n_errors++;
                $display("FAIL miss_hold: got v=%b a=%h wr=%0d required v=1 a=%h wr=%0d",
                         miss_valid, miss_addr, wr_cnt - w0, exp_ma, 0);
            end
            pulse_done();
            #1;
            n_checks++;
            if (miss_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL miss_drop: got miss_valid=%b required 0", miss_valid);
            end
            wait_out(1'b0, n, ok);
            n_checks++;
            if (!ok || n != 2) begin
                n_errors++;
                $display("FAIL fill_latency: got seen=%0b cycles=%0d, required 1/2", ok, n);
            end
            n_checks++;
            if (wr_cnt != w0 + 1 || last_wr_a !== exp_ma[8:4] ||
                last_wr_d !== {9'b0, exp_ma[31:9]} || last_wr_bweb !== 32'h0) begin
                n_errors++;
                $display("FAIL fill_write: got n=%0d A=%0d D=%h BWEB=%h required n=1 A=%0d D=%h BWEB=0",
                         wr_cnt - w0, last_wr_a, last_wr_d, last_wr_bweb,
                         exp_ma[8:4], {9'b0, exp_ma[31:9]});
            end
        end else begin
            wait_out(1'b0, n, ok);
            n_checks++;
            if (!ok || n != 2) begin
                n_errors++;
                $display("FAIL hit_latency: got seen=%0b cycles=%0d, required 1/2", ok, n);
            end
            n_checks++;
            if (miss_seen != m0 || wr_cnt != w0) begin
                n_errors++;
                $display("FAIL hit_quiet: got miss_cycles=%0d writes=%0d required 0/0",
                         miss_seen - m0, wr_cnt - w0);
            end
        end
        n_checks++;
        if (resp_valid !== 1'b1 || resp_hit !== exp_h) begin
            n_errors++;
            $display("FAIL resp_hit: got v=%b hit=%b required v=1 hit=%b", resp_valid, resp_hit, exp_h);
        end
        @(negedge CLK);   // handshake (resp_ready high)
    endtask

    task automatic test_lookup(input logic [31:0] addr);
        logic       ok, ceb;
        logic [4:0] a;
        send_req(addr, ok, ceb, a);
        n_checks++;
        if (!ok || ceb !== 1'b0 || a !== addr[8:4]) begin
            n_errors++;
            $display("FAIL accept %h: got ok=%b CEB=%b A=%0d required 1/0/%0d", addr, ok, ceb, a, addr[8:4]);
        end
        if (ok) complete_lookup();
    endtask

    task automatic test_reset();
        RSTn = 1'b0; preload = 1'b1;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1; preload = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({req_ready, resp_valid, miss_valid, tag_CEB, tag_WEB, resp_hit} !== 6'b100110) begin
            n_errors++;
            $display("FAIL reset_ctl: got rdy/rv/mv/ceb/web/hit=%b required 100110",
                     {req_ready, resp_valid, miss_valid, tag_CEB, tag_WEB, resp_hit});
        end
        n_checks++;
        if (tag_BWEB !== 32'hFFFF_FFFF || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_data: got BWEB=%h hits=%0d misses=%0d required ffffffff/0/0",
                     tag_BWEB, hit_cnt, miss_cnt);
        end
        @(negedge CLK);
    endtask

    task automatic test_cold_miss();  test_lookup(32'h0000_1230); endtask
    task automatic test_hit();        test_lookup(32'h0000_1234); endtask
    task automatic test_conflict();
        test_lookup(32'h0000_3230);
        test_lookup(32'h0000_1230);
    endtask

    task automatic test_invalidate();
        for (int k = 0; k < 2; k++) begin
            inv_valid = 1'b1; inv_index = 5'd3;
            req_valid = 1'b1; req_addr = (k == 0) ? 32'h0000_1230 : 32'h0000_3230;
            #1;
            n_checks++;
            if (req_ready !== 1'b0 || tag_CEB !== 1'b1) begin
                n_errors++;
                $display("FAIL inv_priority: got req_ready=%b CEB=%b required 0/1", req_ready, tag_CEB);
            end
            @(negedge CLK);
            inv_valid = 1'b0;
            mdl_valid[3] = 1'b0;
            test_lookup(req_addr);
        end
    endtask

    task automatic test_backpressure();
        logic       ok, ceb, exp_h;
        logic [4:0] a;
        int         n;
        resp_ready = 1'b0;
        send_req(32'h0000_3230, ok, ceb, a);
        exp_h = resp_exp_q.pop_front();
        wait_out(1'b0, n, ok);
        n_checks++;
        if (!ok || n != 2) begin
            n_errors++;
            $display("FAIL bp_latency: got seen=%0b cycles=%0d, required 1/2", ok, n);
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'h0000_3234;
            inv_valid = 1'b1; inv_index = 5'd3;    // not in IDLE: must be ignored
            #1;
            n_checks++;
            if ({resp_valid, resp_hit, req_ready, tag_CEB} !== {1'b1, exp_h, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got rv/hit/rdy/ceb=%b required %b",
                         i, {resp_valid, resp_hit, req_ready, tag_CEB}, {1'b1, exp_h, 1'b0, 1'b1});
            end
            @(negedge CLK);
        end
        inv_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge CLK); #1;
        n_checks++;
        if (req_ready !== 1'b1 || tag_CEB !== 1'b0 || tag_A !== 5'd3) begin
            n_errors++;
            $display("FAIL back_to_back: got rdy=%b CEB=%b A=%0d required 1/0/3", req_ready, tag_CEB, tag_A);
        end
        @(negedge CLK);
        req_valid = 1'b0;
        predict(32'h0000_3234);
        complete_lookup();
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 8; i++) begin
            addr = (32'($urandom_range(1, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
                 | 32'($urandom_range(0, 15));
            test_lookup(addr);
        end
    endtask

    task automatic test_stats();
        n_checks++;
        if (hit_cnt !== (STAT_EN ? 32'(exp_hits) : 32'd0) ||
            miss_cnt !== (STAT_EN ? 32'(exp_misses) : 32'd0)) begin
            n_errors++;
            $display("FAIL stats: got hits=%0d misses=%0d required %0d/%0d", hit_cnt, miss_cnt,
                     STAT_EN ? exp_hits : 0, STAT_EN ? exp_misses : 0);
        end
    endtask

    task automatic test_reset_in_miss();
        logic        ok, ceb;
        logic [4:0]  a;
        logic [31:0] exp_ma;
        int          n, w0;
        send_req(32'h0000_5670, ok, ceb, a);
        wait_out(1'b1, n, ok);
        exp_ma = miss_exp_q.pop_front();
        n_checks++;
        if (!ok || miss_addr !== exp_ma) begin
            n_errors++;
            $display("FAIL rst_miss_setup: got seen=%b a=%h required 1/%h", ok, miss_addr, exp_ma);
        end
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        w0 = wr_cnt;
        #1;
        n_checks++;
        if (miss_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 ||
            hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_miss_state: got mv=%b rv=%b rdy=%b hits=%0d misses=%0d required 0/0/1/0/0",
                     miss_valid, resp_valid, req_ready, hit_cnt, miss_cnt);
        end
        @(negedge CLK);
        pulse_done();                        // stray pulse in IDLE
        repeat (2) @(negedge CLK);
        #1;
        n_checks++;
        if (wr_cnt != w0 || miss_valid !== 1'b0 || resp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_miss_quiet: got writes=%0d mv=%b rv=%b required 0/0/0",
                     wr_cnt - w0, miss_valid, resp_valid);
        end
        @(negedge CLK);
        test_lookup(32'h0000_3230);          // valid bits cleared: SRAM tag match must not hit
        test_lookup(32'h0000_5670);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        @(negedge CLK);
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_invalidate();
        test_backpressure();
        test_random();
        test_stats();
        test_reset_in_miss();
        test_stats();
        n_checks++;
        if (resp_exp_q.size() != 0 || miss_exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d/%0d entries left required 0/0",
                     resp_exp_q.size(), miss_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion within 200000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
